// File: rtl/axi_mem_slave_plug_if.sv
// axi_mem_slave_plug_if: AXI4 slave channels plus the SRAM-style memory port of axi_mem_slave_plug
interface axi_mem_slave_plug_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 10
);
  localparam int DB = AXI_DATA_WIDTH / 8;
  logic axi_slave_aw_valid, axi_slave_aw_ready;
  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr;
  logic [7:0] axi_slave_aw_len;
  logic [AXI_ID_WIDTH-1:0] axi_slave_aw_id;
  logic axi_slave_ar_valid, axi_slave_ar_ready;
  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr;
  logic [7:0] axi_slave_ar_len;
  logic [AXI_ID_WIDTH-1:0] axi_slave_ar_id;
  logic axi_slave_w_valid, axi_slave_w_ready;
  logic [AXI_DATA_WIDTH-1:0] axi_slave_w_data;
  logic [DB-1:0] axi_slave_w_strb;
  logic axi_slave_r_valid, axi_slave_r_ready, axi_slave_r_last;
  logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data;
  logic [1:0] axi_slave_r_resp;
  logic [AXI_ID_WIDTH-1:0] axi_slave_r_id;
  logic axi_slave_b_valid, axi_slave_b_ready;
  logic [1:0] axi_slave_b_resp;
  logic [AXI_ID_WIDTH-1:0] axi_slave_b_id;
  logic mem_req, mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [AXI_DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [DB-1:0] mem_be;
  modport slave (
    input axi_slave_aw_valid, axi_slave_aw_addr, axi_slave_aw_len, axi_slave_aw_id,
    input axi_slave_ar_valid, axi_slave_ar_addr, axi_slave_ar_len, axi_slave_ar_id,
    input axi_slave_w_valid, axi_slave_w_data, axi_slave_w_strb,
    input axi_slave_r_ready, axi_slave_b_ready, mem_rdata,
    output axi_slave_aw_ready, axi_slave_ar_ready, axi_slave_w_ready,
    output axi_slave_r_valid, axi_slave_r_data, axi_slave_r_resp, axi_slave_r_last, axi_slave_r_id,
    output axi_slave_b_valid, axi_slave_b_resp, axi_slave_b_id,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output axi_slave_aw_valid, axi_slave_aw_addr, axi_slave_aw_len, axi_slave_aw_id,
    output axi_slave_ar_valid, axi_slave_ar_addr, axi_slave_ar_len, axi_slave_ar_id,
    output axi_slave_w_valid, axi_slave_w_data, axi_slave_w_strb,
    output axi_slave_r_ready, axi_slave_b_ready, mem_rdata,
    input axi_slave_aw_ready, axi_slave_ar_ready, axi_slave_w_ready,
    input axi_slave_r_valid, axi_slave_r_data, axi_slave_r_resp, axi_slave_r_last, axi_slave_r_id,
    input axi_slave_b_valid, axi_slave_b_resp, axi_slave_b_id,
    input mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/axi_mem_slave_plug.sv
// axi_mem_slave_plug: AXI4 INCR burst responder onto a 1-cycle-latency SRAM port; define AXI_SLV_RANGE_CHK_EN for out-of-range SLVERR
module axi_mem_slave_plug #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input logic axi_aclk,
  input logic axi_areset,
  axi_mem_slave_plug_if.slave bus
);
  localparam int DB = AXI_DATA_WIDTH / 8;
  localparam int LB = $clog2(DB);
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;
  state_t r_state, w_next;
  logic r_prio_wr, r_inflight, r_oor, r_last_pend, r_err, r_rvalid, r_rlast;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0] r_len;
  logic [AXI_ID_WIDTH-1:0] r_txn_id;
  logic [8:0] r_cnt;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0] r_rresp;
  logic w_both, w_grant_w, w_grant_r, w_wbeat, w_rissue, w_last, w_in_range, w_req;
`ifdef AXI_SLV_RANGE_CHK_EN
  assign w_in_range = (r_addr >> (MEM_ADDR_WIDTH + LB)) == '0;
`else
  assign w_in_range = 1'b1;
`endif
  // priority only flips when both requests contend
  assign w_both = bus.axi_slave_aw_valid && bus.axi_slave_ar_valid;
  assign w_grant_w = r_state == IDLE && bus.axi_slave_aw_valid && (!bus.axi_slave_ar_valid || r_prio_wr);
  assign w_grant_r = r_state == IDLE && bus.axi_slave_ar_valid && !w_grant_w;
  assign w_wbeat = r_state == WRITE && bus.axi_slave_w_valid;
  assign w_rissue = r_state == READ && !r_inflight && (!r_rvalid || bus.axi_slave_r_ready) && r_cnt <= {1'b0, r_len};
  assign w_last = r_cnt[7:0] == r_len;
  assign w_req = (w_wbeat || w_rissue) && w_in_range;
  always_comb begin
    w_next = r_state;
    if (w_grant_w) w_next = WRITE;
    else if (w_grant_r) w_next = READ;
    else if (w_wbeat && w_last) w_next = WRESP;
    else if (r_state == WRESP && bus.axi_slave_b_ready) w_next = IDLE;
    else if (r_state == READ && r_rvalid && bus.axi_slave_r_ready && r_rlast) w_next = IDLE;
    bus.axi_slave_aw_ready = w_grant_w;
    bus.axi_slave_ar_ready = w_grant_r;
    bus.axi_slave_w_ready = r_state == WRITE;
    bus.axi_slave_b_valid = r_state == WRESP;
    bus.axi_slave_b_resp = r_state == WRESP ? {r_err, 1'b0} : 2'b00;
    bus.axi_slave_b_id = r_state == WRESP ? r_txn_id : '0;
    bus.axi_slave_r_valid = r_rvalid;
    bus.axi_slave_r_data = r_rdata;
    bus.axi_slave_r_resp = r_rresp;
    bus.axi_slave_r_last = r_rvalid && r_rlast;
    bus.axi_slave_r_id = r_rvalid ? r_txn_id : '0;
    bus.mem_req = w_req;
    bus.mem_we = w_req && w_wbeat;
    bus.mem_addr = w_req ? r_addr[MEM_ADDR_WIDTH+LB-1:LB] : '0;
    bus.mem_wdata = w_req && w_wbeat ? bus.axi_slave_w_data : '0;
    bus.mem_be = !w_req ? '0 : w_wbeat ? bus.axi_slave_w_strb : '1;
  end
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state <= IDLE;
      r_prio_wr <= 1'b1;
      r_inflight <= 1'b0;
      r_oor <= 1'b0;
      r_last_pend <= 1'b0;
      r_err <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast <= 1'b0;
      r_addr <= '0;
      r_len <= '0;
      r_txn_id <= '0;
      r_cnt <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
    end else begin
      r_state <= w_next;
      r_inflight <= w_rissue;
      if (w_grant_w || w_grant_r) begin
        r_addr <= w_grant_w ? bus.axi_slave_aw_addr : bus.axi_slave_ar_addr;
        r_len <= w_grant_w ? bus.axi_slave_aw_len : bus.axi_slave_ar_len;
        r_txn_id <= w_grant_w ? bus.axi_slave_aw_id : bus.axi_slave_ar_id;
        r_cnt <= '0;
        r_err <= 1'b0;
        if (w_both) r_prio_wr <= !w_grant_w;
      end
      if (w_wbeat || w_rissue) begin
        r_addr <= r_addr + AXI_ADDR_WIDTH'(DB);
        r_cnt <= r_cnt + 9'd1;
      end
      if (w_wbeat && !w_in_range) r_err <= 1'b1;
      if (w_rissue) begin
        r_oor <= !w_in_range;
        r_last_pend <= w_last;
      end
      // a read is only issued once the previous beat is consumed, so capture never overwrites a pending beat
      if (r_inflight) begin
        r_rvalid <= 1'b1;
        r_rdata <= r_oor ? '0 : bus.mem_rdata;
        r_rresp <= r_oor ? 2'b10 : 2'b00;
        r_rlast <= r_last_pend;
      end else if (r_rvalid && bus.axi_slave_r_ready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_slave_plug.sv
// tb_axi_mem_slave_plug: directed AXI read/write bursts against axi_mem_slave_plug with a 1-cycle SRAM model
module tb_axi_mem_slave_plug;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] mem [1024];
  logic [9:0] q_addr [$];
  logic q_we [$];
  logic [7:0] q_be [$];
  logic [63:0] q_wd [$];
  int q_ord [$];
  logic [63:0] rd_data [16];
  logic rd_last [16];
  logic [1:0] rd_resp [16];
  logic [2:0] rd_id [16];
  int rd_n;
  logic [1:0] bresp;
  logic [2:0] bid;
  logic [63:0] exp2 [4];
  axi_mem_slave_plug_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(3), .MEM_ADDR_WIDTH(10)) bus ();
  axi_mem_slave_plug #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(3), .MEM_ADDR_WIDTH(10)) dut (
    .axi_aclk(clk),
    .axi_areset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) mem[i] <= 64'hA5A5_0000_0000_0000 + 64'(i);
    else if (bus.mem_req && bus.mem_we)
      for (int b = 0; b < 8; b++) if (bus.mem_be[b]) mem[bus.mem_addr][8*b+:8] <= bus.mem_wdata[8*b+:8];
    if (bus.mem_req && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
  end
  always @(posedge clk) begin
    if (!rst && bus.mem_req) begin
      q_addr.push_back(bus.mem_addr);
      q_we.push_back(bus.mem_we);
      q_be.push_back(bus.mem_be);
      q_wd.push_back(bus.mem_wdata);
    end
    if (!rst && bus.axi_slave_aw_valid && bus.axi_slave_aw_ready) q_ord.push_back(1);
    if (!rst && bus.axi_slave_ar_valid && bus.axi_slave_ar_ready) q_ord.push_back(0);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_logs();
    q_addr.delete();
    q_we.delete();
    q_be.delete();
    q_wd.delete();
    q_ord.delete();
  endtask
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id,
                           input logic [63:0] base, output logic [1:0] resp, output logic [2:0] rid);
    bit hs;
    resp = 2'bxx;
    rid = 3'bxxx;
    bus.axi_slave_aw_valid = 1'b1;
    bus.axi_slave_aw_addr = addr;
    bus.axi_slave_aw_len = len;
    bus.axi_slave_aw_id = id;
    hs = 1'b0;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = bus.axi_slave_aw_ready;
    end
    chk("aw_handshake", 64'(hs), 64'd1);
    @(posedge clk);
    #1 bus.axi_slave_aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bus.axi_slave_w_valid = 1'b1;
      bus.axi_slave_w_data = base + 64'(k);
      bus.axi_slave_w_strb = 8'hFF;
      hs = 1'b0;
      for (int t = 0; t < 100 && !hs; t++) begin
        @(negedge clk);
        hs = bus.axi_slave_w_ready;
      end
      chk("w_handshake", 64'(hs), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.axi_slave_w_valid = 1'b0;
    bus.axi_slave_b_ready = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = bus.axi_slave_b_valid;
      if (hs) begin
        resp = bus.axi_slave_b_resp;
        rid = bus.axi_slave_b_id;
      end
    end
    chk("b_handshake", 64'(hs), 64'd1);
    @(posedge clk);
    #1 bus.axi_slave_b_ready = 1'b0;
  endtask
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id, input bit tog);
    bit hs;
    bit rr;
    bus.axi_slave_ar_valid = 1'b1;
    bus.axi_slave_ar_addr = addr;
    bus.axi_slave_ar_len = len;
    bus.axi_slave_ar_id = id;
    hs = 1'b0;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = bus.axi_slave_ar_ready;
    end
    chk("ar_handshake", 64'(hs), 64'd1);
    @(posedge clk);
    #1 bus.axi_slave_ar_valid = 1'b0;
    rd_n = 0;
    rr = 1'b1;
    for (int c = 0; c < 200 && rd_n <= int'(len) && rd_n < 16; c++) begin
      bus.axi_slave_r_ready = rr;
      @(negedge clk);
      if (bus.axi_slave_r_valid && bus.axi_slave_r_ready) begin
        rd_data[rd_n] = bus.axi_slave_r_data;
        rd_last[rd_n] = bus.axi_slave_r_last;
        rd_resp[rd_n] = bus.axi_slave_r_resp;
        rd_id[rd_n] = bus.axi_slave_r_id;
        rd_n++;
      end
      @(posedge clk);
      #1 rr = tog ? !rr : 1'b1;
    end
    bus.axi_slave_r_ready = 1'b0;
    chk("r_beat_count", 64'(rd_n), 64'(int'(len) + 1));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp2 = '{64'hA5A5_0000_0000_0000, 64'hA5A5_0000_0000_0001, 64'h1122_3344_5566_7788, 64'hA5A5_0000_0000_0003};
    bus.axi_slave_aw_valid = 1'b0;
    bus.axi_slave_aw_addr = '0;
    bus.axi_slave_aw_len = '0;
    bus.axi_slave_aw_id = '0;
    bus.axi_slave_ar_valid = 1'b0;
    bus.axi_slave_ar_addr = '0;
    bus.axi_slave_ar_len = '0;
    bus.axi_slave_ar_id = '0;
    bus.axi_slave_w_valid = 1'b0;
    bus.axi_slave_w_data = '0;
    bus.axi_slave_w_strb = '0;
    bus.axi_slave_r_ready = 1'b0;
    bus.axi_slave_b_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 64'(bus.axi_slave_aw_ready), 64'd0);
    chk("rst_ar_ready", 64'(bus.axi_slave_ar_ready), 64'd0);
    chk("rst_w_ready", 64'(bus.axi_slave_w_ready), 64'd0);
    chk("rst_r_valid", 64'(bus.axi_slave_r_valid), 64'd0);
    chk("rst_b_valid", 64'(bus.axi_slave_b_valid), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    fork
      axi_write(32'h40, 8'd1, 3'd2, 64'hDEAD_0000_0000_0000, bresp, bid);
      axi_read(32'h8, 8'd0, 3'd3, 1'b0);
    join
    chk("arb1_count", 64'(q_ord.size()), 64'd2);
    chk("arb1_first_write", 64'(q_ord[0]), 64'd1);
    chk("arb1_second_read", 64'(q_ord[1]), 64'd0);
    chk("arb1_nreq", 64'(q_addr.size()), 64'd3);
    chk("arb1_addr0", 64'(q_addr[0]), 64'd8);
    chk("arb1_addr1", 64'(q_addr[1]), 64'd9);
    chk("arb1_addr2", 64'(q_addr[2]), 64'd1);
    chk("arb1_we2", 64'(q_we[2]), 64'd0);
    chk("arb1_wdata1", q_wd[1], 64'hDEAD_0000_0000_0001);
    chk("arb1_bid", 64'(bid), 64'd2);
    chk("arb1_rdata", rd_data[0], 64'hA5A5_0000_0000_0001);
    chk("arb1_rid", 64'(rd_id[0]), 64'd3);
    chk("arb1_rlast", 64'(rd_last[0]), 64'd1);
    repeat (2) @(posedge clk);
    #1 clear_logs();
    fork
      axi_write(32'h60, 8'd0, 3'd4, 64'hBEEF_0000_0000_0000, bresp, bid);
      axi_read(32'h40, 8'd0, 3'd6, 1'b0);
    join
    chk("arb2_first_read", 64'(q_ord[0]), 64'd0);
    chk("arb2_second_write", 64'(q_ord[1]), 64'd1);
    chk("arb2_addr0", 64'(q_addr[0]), 64'd8);
    chk("arb2_addr1", 64'(q_addr[1]), 64'd12);
    chk("arb2_rdata", rd_data[0], 64'hDEAD_0000_0000_0000);
    chk("arb2_rid", 64'(rd_id[0]), 64'd6);
    chk("arb2_bid", 64'(bid), 64'd4);
    repeat (2) @(posedge clk);
    #1 clear_logs();
    axi_write(32'h10, 8'd0, 3'd5, 64'h1122_3344_5566_7788, bresp, bid);
    chk("wr_nreq", 64'(q_addr.size()), 64'd1);
    chk("wr_addr", 64'(q_addr[0]), 64'd2);
    chk("wr_we", 64'(q_we[0]), 64'd1);
    chk("wr_be", 64'(q_be[0]), 64'hFF);
    chk("wr_wdata", q_wd[0], 64'h1122_3344_5566_7788);
    chk("wr_bid", 64'(bid), 64'd5);
    chk("wr_bresp", 64'(bresp), 64'd0);
    chk("wr_mem", mem[2], 64'h1122_3344_5566_7788);
    repeat (2) @(posedge clk);
    #1 clear_logs();
    axi_read(32'h0, 8'd3, 3'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_data%0d", i), rd_data[i], exp2[i]);
      chk($sformatf("rd_last%0d", i), 64'(rd_last[i]), i == 3 ? 64'd1 : 64'd0);
      chk($sformatf("rd_addr%0d", i), 64'(q_addr[i]), 64'(i));
      chk($sformatf("rd_be%0d", i), 64'(q_be[i]), 64'hFF);
      chk($sformatf("rd_resp%0d", i), 64'(rd_resp[i]), 64'd0);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rd_no_extra_req", 64'(q_addr.size()), 64'd4);
    chk("rd_no_extra_beat", 64'(bus.axi_slave_r_valid), 64'd0);
    @(posedge clk);
    #1 clear_logs();
    axi_write(32'h2000, 8'd0, 3'd1, 64'h5555_5555_5555_5555, bresp, bid);
    axi_read(32'h2000, 8'd0, 3'd2, 1'b0);
`ifdef AXI_SLV_RANGE_CHK_EN
    chk("oor_nreq", 64'(q_addr.size()), 64'd0);
    chk("oor_bresp", 64'(bresp), 64'd2);
    chk("oor_rdata", rd_data[0], 64'd0);
    chk("oor_rresp", 64'(rd_resp[0]), 64'd2);
`else
    chk("alias_nreq", 64'(q_addr.size()), 64'd2);
    chk("alias_waddr", 64'(q_addr[0]), 64'd0);
    chk("alias_raddr", 64'(q_addr[1]), 64'd0);
    chk("alias_bresp", 64'(bresp), 64'd0);
    chk("alias_rdata", rd_data[0], 64'h5555_5555_5555_5555);
    chk("alias_rresp", 64'(rd_resp[0]), 64'd0);
`endif
    chk("oor_bid", 64'(bid), 64'd1);
    chk("oor_rid", 64'(rd_id[0]), 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
